// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-requester AXI read arbiter sharing one AR/R port.
// Round-robin grant with one outstanding burst; grant is held from AR issue
// until the R beat carrying last handshakes. IDs and resp pass through.
// Ports: clk, rst (async, active-high); s0_*/s1_* requester AR/R channels;
// m_* shared AR/R channel; grant (one-hot owner, 00 idle); busy.
// Optional macro RD_ARB_STATS_EN adds stat_grants0/1 and stat_wait_max.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 6,
    parameter int AR_W       = ID_WIDTH + ADDR_WIDTH + 13,
    parameter int R_W        = ID_WIDTH + DATA_WIDTH + 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_ar_valid,
    output logic            s0_ar_ready,
    input  logic [AR_W-1:0] s0_ar_payload,
    output logic            s0_r_valid,
    input  logic            s0_r_ready,
    output logic [R_W-1:0]  s0_r_payload,
    input  logic            s1_ar_valid,
    output logic            s1_ar_ready,
    input  logic [AR_W-1:0] s1_ar_payload,
    output logic            s1_r_valid,
    input  logic            s1_r_ready,
    output logic [R_W-1:0]  s1_r_payload,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AR_W-1:0] m_ar_payload,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W-1:0]  m_r_payload,
    output logic [1:0]      grant,
    output logic            busy
`ifdef RD_ARB_STATS_EN
    ,
    output logic [31:0]     stat_grants0,
    output logic [31:0]     stat_grants1,
    output logic [15:0]     stat_wait_max
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    // Index of the requester served most recently; 1 so that 0 wins first.
    logic       last_grant_q, last_grant_d;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s0_ar_ready  = 1'b0;
        s1_ar_ready  = 1'b0;
        s0_r_valid   = 1'b0;
        s1_r_valid   = 1'b0;
        s0_r_payload = '0;
        s1_r_payload = '0;
        m_ar_valid   = 1'b0;
        m_ar_payload = '0;
        m_r_ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s0_ar_valid && s1_ar_valid) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                end else if (s0_ar_valid) begin
                    grant_d = 2'b01;
                end else if (s1_ar_valid) begin
                    grant_d = 2'b10;
                end
                if (s0_ar_valid || s1_ar_valid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_ar_valid   = 1'b1;
                m_ar_payload = grant_q[1] ? s1_ar_payload : s0_ar_payload;
                s0_ar_ready  = grant_q[0] & m_ar_ready;
                s1_ar_ready  = grant_q[1] & m_ar_ready;
                if (m_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s0_r_valid   = grant_q[0] & m_r_valid;
                s1_r_valid   = grant_q[1] & m_r_valid;
                s0_r_payload = grant_q[0] ? m_r_payload : '0;
                s1_r_payload = grant_q[1] ? m_r_payload : '0;
                m_r_ready    = (grant_q[0] & s0_r_ready)
                             | (grant_q[1] & s1_r_ready);
                // Burst ends on the last flag alone; no beat counting.
                if (m_r_valid && m_r_ready && m_r_payload[0]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

`ifdef RD_ARB_STATS_EN
    logic [31:0] grants0_q, grants0_d;
    logic [31:0] grants1_q, grants1_d;
    logic [15:0] wait0_q, wait0_d;
    logic [15:0] wait1_q, wait1_d;
    logic [15:0] wait_max_q, wait_max_d;
    logic        hs0, hs1;

    assign hs0 = s0_ar_valid & s0_ar_ready;
    assign hs1 = s1_ar_valid & s1_ar_ready;

    // waitN counts cycles valid was held before the handshake cycle.
    always_comb begin
        grants0_d  = grants0_q;
        grants1_d  = grants1_q;
        wait0_d    = 16'd0;
        wait1_d    = 16'd0;
        wait_max_d = wait_max_q;
        if (hs0 && grants0_q != 32'hFFFF_FFFF) begin
            grants0_d = grants0_q + 32'd1;
        end
        if (hs1 && grants1_q != 32'hFFFF_FFFF) begin
            grants1_d = grants1_q + 32'd1;
        end
        if (s0_ar_valid && !hs0) begin
            wait0_d = (wait0_q == 16'hFFFF) ? wait0_q : wait0_q + 16'd1;
        end
        if (s1_ar_valid && !hs1) begin
            wait1_d = (wait1_q == 16'hFFFF) ? wait1_q : wait1_q + 16'd1;
        end
        if (hs0 && wait0_q > wait_max_q) begin
            wait_max_d = wait0_q;
        end
        if (hs1 && wait1_q > wait_max_q) begin
            wait_max_d = wait1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants0_q  <= 32'd0;
            grants1_q  <= 32'd0;
            wait0_q    <= 16'd0;
            wait1_q    <= 16'd0;
            wait_max_q <= 16'd0;
        end else begin
            grants0_q  <= grants0_d;
            grants1_q  <= grants1_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            wait_max_q <= wait_max_d;
        end
    end

    assign stat_grants0  = grants0_q;
    assign stat_grants1  = grants1_q;
    assign stat_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized scoreboard bench for axi_rd_arbiter.
// Reference model predicts arbitration winners and routing of R beats.
module tb_axi_rd_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int IW   = 6;
    localparam int AR_W = IW + AW + 13;
    localparam int R_W  = IW + DW + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]      sv;
    logic [1:0]      sarr;
    logic [1:0]      srv;
    logic [1:0]      srr;
    logic [AR_W-1:0] sp [2];
    logic [R_W-1:0]  srp0, srp1;
    logic            m_ar_valid, m_ar_ready;
    logic [AR_W-1:0] m_ar_payload;
    logic            m_r_valid, m_r_ready;
    logic [R_W-1:0]  m_r_payload;
    logic [1:0]      grant;
    logic            busy;
`ifdef RD_ARB_STATS_EN
    logic [31:0]     stat_grants0, stat_grants1;
    logic [15:0]     stat_wait_max;
`endif

    axi_rd_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .s0_ar_valid   (sv[0]),
        .s0_ar_ready   (sarr[0]),
        .s0_ar_payload (sp[0]),
        .s0_r_valid    (srv[0]),
        .s0_r_ready    (srr[0]),
        .s0_r_payload  (srp0),
        .s1_ar_valid   (sv[1]),
        .s1_ar_ready   (sarr[1]),
        .s1_ar_payload (sp[1]),
        .s1_r_valid    (srv[1]),
        .s1_r_ready    (srr[1]),
        .s1_r_payload  (srp1),
        .m_ar_valid    (m_ar_valid),
        .m_ar_ready    (m_ar_ready),
        .m_ar_payload  (m_ar_payload),
        .m_r_valid     (m_r_valid),
        .m_r_ready     (m_r_ready),
        .m_r_payload   (m_r_payload),
        .grant         (grant),
        .busy          (busy)
`ifdef RD_ARB_STATS_EN
        ,
        .stat_grants0  (stat_grants0),
        .stat_grants1  (stat_grants1),
        .stat_wait_max (stat_wait_max)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int              who;
        logic [AR_W-1:0] p;
    } ar_e;
    typedef struct {
        int             who;
        logic [R_W-1:0] p;
    } r_e;

    ar_e exp_ar[$];
    r_e  exp_r[$];

    // Model: 0 idle, 1 address issued, 2 data; owner and last winner.
    int  phase = 0;
    int  owner = 0;
    int  last_w = 1;
    bit  mon_en = 0;
    bit  rr_rand = 0;
    int  cyc = 0;
    int  gcnt [2];
    int  wstart [2];
    bit  waiting [2];
    int  wmax = 0;
    ar_e ea;
    r_e  er;
    logic [R_W-1:0] rp;

    function automatic logic [R_W-1:0] rpay(input int i);
        return i == 1 ? srp1 : srp0;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        srr = rr_rand ? 2'($urandom) : 2'b11;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (sv[i] && !waiting[i]) begin
                    waiting[i] = 1;
                    wstart[i] = cyc;
                end
            end
            chk("busy", busy, phase != 0);
            chk("grant", grant,
                phase == 0 ? 2'b00 : (owner == 1 ? 2'b10 : 2'b01));
            chk("m_ar_valid", m_ar_valid, phase == 1);
            for (int i = 0; i < 2; i++) begin
                chk("s_ar_ready", sarr[i],
                    (phase == 1 && owner == i) ? m_ar_ready : 1'b0);
                chk("s_r_valid", srv[i],
                    (phase == 2 && owner == i) ? m_r_valid : 1'b0);
            end
            chk("m_r_ready", m_r_ready, phase == 2 ? srr[owner] : 1'b0);
            if (m_ar_valid && m_ar_ready) begin
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1'b1, 1'b0);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_owner", grant, ea.who == 1 ? 2'b10 : 2'b01);
                    chk("ar_payload", m_ar_payload, ea.p);
                    gcnt[ea.who]++;
                    waiting[ea.who] = 0;
                    if (cyc - wstart[ea.who] > wmax) begin
                        wmax = cyc - wstart[ea.who];
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (srv[i] && srr[i]) begin
                    rp = rpay(i);
                    if (exp_r.size() == 0) begin
                        chk("r_unexpected", 1'b1, 1'b0);
                    end else begin
                        er = exp_r.pop_front();
                        chk("r_dest", i, er.who);
                        chk("r_payload", rp, er.p);
                    end
                end
            end
            case (phase)
                0: if (sv != 2'b00) begin
                    if (sv == 2'b11) owner = (last_w == 0) ? 1 : 0;
                    else owner = sv[1] ? 1 : 0;
                    exp_ar.push_back('{owner, sp[owner]});
                    phase = 1;
                end
                1: if (m_ar_ready) phase = 2;
                default: if (m_r_valid && srr[owner] && m_r_payload[0]) begin
                    phase = 0;
                    last_w = owner;
                end
            endcase
        end
    end

    task automatic req_run(input int i, input int n, input int gapmax,
                           input int lenmax);
        int gap;
        int t;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, gapmax);
            if (gap > 0) begin
                sv[i] = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            sp[i] = {6'($urandom), 32'($urandom),
                     8'($urandom_range(0, lenmax)), 3'd3, 2'd1};
            sv[i] = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (sarr[i]) break;
                t++;
                if (t > 5000) break;
            end
            if (t > 5000) begin
                chk("ar_timeout", 1'b1, 1'b0);
                sv[i] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sv[i] = 1'b0;
    endtask

    task automatic slave_run(input int n);
        int done = 0;
        int t = 0;
        int len;
        logic [IW-1:0] id;
        logic [R_W-1:0] beats[$];
        while (done < n && t < 20000) begin
            @(posedge clk);
            #1;
            m_ar_ready  = 1'($urandom);
            m_r_valid   = ($urandom_range(0, 3) == 0);
            m_r_payload = {IW'($urandom), 32'($urandom), 32'($urandom),
                           3'b001};
            t++;
            @(negedge clk);
            if (m_ar_valid && m_ar_ready) begin
                len = int'(m_ar_payload[12:5]);
                id  = m_ar_payload[AR_W-1 -: IW];
                beats.delete();
                for (int b = 0; b <= len; b++) begin
                    beats.push_back({id, 32'($urandom), 32'($urandom),
                                     2'($urandom), b == len});
                    exp_r.push_back('{owner, beats[b]});
                end
                for (int b = 0; b <= len; b++) begin
                    forever begin
                        @(posedge clk);
                        #1;
                        m_ar_ready  = 1'b0;
                        m_r_valid   = ($urandom_range(0, 3) != 0);
                        m_r_payload = beats[b];
                        t++;
                        @(negedge clk);
                        if ((m_r_valid && m_r_ready) || t >= 20000) break;
                    end
                end
                done++;
            end
        end
        if (done < n) chk("slave_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
    endtask

    task automatic reset_model();
        phase = 0;
        last_w = 1;
        exp_ar.delete();
        exp_r.delete();
        gcnt[0] = 0;
        gcnt[1] = 0;
        waiting[0] = 0;
        waiting[1] = 0;
        wmax = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_m_ar_valid"}, m_ar_valid, 1'b0);
        chk({tag, "_m_r_ready"}, m_r_ready, 1'b0);
        chk({tag, "_s_ar_ready"}, sarr, 2'b00);
        chk({tag, "_s_r_valid"}, srv, 2'b00);
    endtask

    initial begin
        int t;
        sv = 2'b00;
        sp[0] = '0;
        sp[1] = '0;
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1;
        m_r_payload = '1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        m_r_valid = 1'b0;
        rst = 1'b0;
        mon_en = 1;

        fork
            req_run(0, 1, 0, 3);
            slave_run(1);
        join
        fork
            req_run(0, 1, 0, 3);
            req_run(1, 1, 0, 3);
            slave_run(2);
        join
        rr_rand = 1;
        fork
            req_run(0, 20, 4, 3);
            req_run(1, 20, 4, 3);
            slave_run(40);
        join
        rr_rand = 0;
        fork
            req_run(0, 3, 0, 0);
            req_run(1, 3, 0, 0);
            slave_run(6);
        join
        fork
            req_run(0, 1, 0, 7);
            slave_run(1);
        join
        repeat (4) @(posedge clk);
        #1;
        chk("exp_ar_drained", exp_ar.size(), 0);
        chk("exp_r_drained", exp_r.size(), 0);
`ifdef RD_ARB_STATS_EN
        chk("stat_grants0", stat_grants0, gcnt[0]);
        chk("stat_grants1", stat_grants1, gcnt[1]);
        chk("stat_wait_max", stat_wait_max, wmax);
`endif

        // Asynchronous reset in the middle of a 4-beat burst.
        mon_en = 0;
        sp[0] = {6'h2a, 32'h0000_0100, 8'd3, 3'd3, 2'd1};
        sv[0] = 1'b1;
        m_ar_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m_ar_valid && m_ar_ready) && t < 50);
        chk("rst_ar_issued", m_ar_valid, 1'b1);
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1;
        m_r_payload = {6'h2a, 64'h1234_5678_9abc_def0, 2'b00, 1'b0};
        @(negedge clk);
        chk("rst_beat_routed", srv, 2'b01);
        chk("rst_beat_ready", m_r_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        m_r_valid = 1'b0;
        rst = 1'b0;
        reset_model();
        mon_en = 1;
        fork
            req_run(1, 1, 0, 2);
            slave_run(1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ar_drained", exp_ar.size(), 0);
        chk("post_rst_r_drained", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
